regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It succeeds the single-write, two-read combinational register file with the following changes:
- configurable data width, depth, read-port count and write-port count;
- asynchronous clear of all state;
- registered, write-first reads;
- hardwired-zero register 0 as an option;
- a busy scoreboard so issue logic can track in-flight destinations.

It sits between the decode/issue stage (reserve, read) and writeback (write) of the CPU pipeline.

## Interface
- DATA_BITS, 32, register width in bits
- LOG2_NUM_REGISTERS, 5, address width; depth NUM_REGISTERS = 1 << LOG2_NUM_REGISTERS
- NUM_READ_PORTS, 2, read ports (1..4)
- NUM_WRITE_PORTS, 2, write ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reserves

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  reset, asynchronous and active-low
- wen  input  NUM_WRITE_PORTS  per-port write enable
- waddr  input  NUM_WRITE_PORTS*LOG2_NUM_REGISTERS  write addresses, port w at slice w
- wdata  input  NUM_WRITE_PORTS*DATA_BITS  write data, port w at slice w
- rsv_en  input  1  mark rsv_addr busy
- rsv_addr  input  LOG2_NUM_REGISTERS  register to reserve
- ren  input  NUM_READ_PORTS  per-port read enable
- raddr  input  NUM_READ_PORTS*LOG2_NUM_REGISTERS  read addresses
- rdata  output  NUM_READ_PORTS*DATA_BITS  registered read data
- rbusy  output  NUM_READ_PORTS  registered busy bit of the addressed register
- busy_vec  output  NUM_REGISTERS  current scoreboard, bit i = register i busy

## Operation
**Reset.** While reset_n = 0, all of the following are forced to 0 immediately, without waiting for a clock:
- every register;
- every busy bit;
- rdata, rbusy and busy_vec.

**Writes.**
- A write port with wen set updates register waddr at the clock edge.
- If ZERO_REG = 1 and waddr = 0, the write is dropped.
- If several write ports target the same address in the same cycle, the highest-indexed port wins.
- A write to register a clears busy[a] at the same edge.

**Reserve.**
- rsv_en sets busy[rsv_addr] at the edge.
- If ZERO_REG = 1 and rsv_addr = 0, the reserve is ignored.
- If a reserve and a write hit the same address in the same cycle, the reserve wins: busy stays 1 and the data is still written.

**Reads.**
- A read port with ren set captures, at the edge, the post-update value of register raddr into its rdata slice.
- The captured value is write-first: if a write to raddr happens in that cycle, rdata gets the winning write data.
- rbusy for that port captures the post-update busy bit, including that cycle's reserve and clear.
- If ren is 0, rdata and rbusy hold their previous values.
- If ZERO_REG = 1 and raddr = 0, the port returns rdata = 0 and rbusy = 0.

**Other rules.**
- busy_vec is the registered scoreboard state; it is not bypassed.
- No arithmetic is performed; data passes through unmodified at full DATA_BITS width.
- Out-of-range addresses cannot occur, because the depth is exactly a power of two.

## Timing
- Write to storage: takes effect at the edge; visible to a read issued in the same cycle (bypass).
- Read latency: 1 cycle. ren/raddr in cycle t produce rdata/rbusy valid from the edge ending cycle t.
- Reserve to busy_vec: 1 cycle. Write clearing busy to busy_vec: 1 cycle.
- There is no handshake or backpressure; every port accepts a request every cycle.
- Reset asserted mid-operation:
  - state is cleared asynchronously;
  - pending reads are lost; rdata = 0 until the first ren after release.
- After reset_n deasserts, the first edge at which reset_n is sampled high is a normal cycle.
- Reset deassertion is synchronised externally; the block does not resynchronise it.

## Test plan
- **Reset value.** Write 0xDEADBEEF to r5, then assert reset_n = 0 mid-cycle. Required:
  - rdata, rbusy and busy_vec go to 0 before the next edge;
  - after release, reading r5 returns 0.
- **Write-first bypass.** Port 0 writes 0x12345678 to r7 while read port 1 reads r7 in the same cycle. Required: rdata1 = 0x12345678 one cycle later. A read of r7 the cycle before returns the old value.
- **Write conflict.** Port 0 writes 0xAAAA0000 and port 1 writes 0x0000BBBB to r3 in the same cycle. Required: a later read of r3 returns 0x0000BBBB.
- **Scoreboard.** Check each of the following:
  - Reserve r9: busy_vec[9] = 1 one cycle later, and a read of r9 shows rbusy = 1.
  - Write r9 = 0x55: busy_vec[9] = 0 next cycle.
  - Reserve and write r9 in the same cycle: busy_vec[9] stays 1 and r9 reads 0x55.
- **Zero register.** With ZERO_REG = 1, write 0xFFFFFFFF to r0 and reserve r0. Required:
  - a read of r0 returns rdata = 0 and rbusy = 0;
  - busy_vec[0] = 0.
- **Hold and parameters.** With ren low for 3 cycles after reading r4 = 0x44, rdata stays 0x44 while r4 is rewritten to 0x99. Repeat the suite with DATA_BITS = 64, LOG2_NUM_REGISTERS = 6, 4 read ports and 3 write ports.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a busy scoreboard.
// Writes, reserves and reads all resolve against the post-update state, so a
// read issued in the same cycle as a write or reserve sees its effect.

// One registered read port: captures the selected post-update register value
// and busy bit when enabled, otherwise holds.
module regfile_mp_rdport #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ren,
  input  logic                 zero_sel,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 busy_in,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rbusy
);

  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 rbusy_q, rbusy_d;

  // capture on ren, hold otherwise; hardwired zero register forces 0/0
  always_comb begin
    rdata_d = rdata_q;
    rbusy_d = rbusy_q;
    if (ren) begin
      rdata_d = zero_sel ? '0   : data_in;
      rbusy_d = zero_sel ? 1'b0 : busy_in;
    end
  end

  // read output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rbusy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;

endmodule

module regfile_mp #(
  parameter int DATA_BITS          = 32,
  parameter int LOG2_NUM_REGISTERS = 5,
  parameter int NUM_READ_PORTS     = 2,
  parameter int NUM_WRITE_PORTS    = 2,
  parameter int ZERO_REG           = 1,
  localparam int NUM_REGISTERS     = 1 << LOG2_NUM_REGISTERS
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_WRITE_PORTS-1:0]                   wen,
  input  logic [NUM_WRITE_PORTS*LOG2_NUM_REGISTERS-1:0] waddr,
  input  logic [NUM_WRITE_PORTS*DATA_BITS-1:0]          wdata,
  input  logic                                         rsv_en,
  input  logic [LOG2_NUM_REGISTERS-1:0]                rsv_addr,
  input  logic [NUM_READ_PORTS-1:0]                    ren,
  input  logic [NUM_READ_PORTS*LOG2_NUM_REGISTERS-1:0]  raddr,
  output logic [NUM_READ_PORTS*DATA_BITS-1:0]           rdata,
  output logic [NUM_READ_PORTS-1:0]                    rbusy,
  output logic [NUM_REGISTERS-1:0]                     busy_vec
);

  localparam int AW = LOG2_NUM_REGISTERS;

  logic [NUM_WRITE_PORTS-1:0][AW-1:0]        waddr_a;
  logic [NUM_WRITE_PORTS-1:0][DATA_BITS-1:0] wdata_a;
  logic [NUM_READ_PORTS-1:0][AW-1:0]         raddr_a;
  logic [NUM_READ_PORTS-1:0][DATA_BITS-1:0]  rdata_a;

  assign waddr_a = waddr;
  assign wdata_a = wdata;
  assign raddr_a = raddr;
  assign rdata   = rdata_a;

  logic [NUM_REGISTERS-1:0][DATA_BITS-1:0] regs_q, regs_d;
  logic [NUM_REGISTERS-1:0]                busy_q, busy_d;

  // next state: writes in ascending port order so the highest port wins,
  // each write clears busy, then the reserve sets busy and so overrides it
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (wen[w] && !((ZERO_REG != 0) && (waddr_a[w] == '0))) begin
        regs_d[waddr_a[w]] = wdata_a[w];
        busy_d[waddr_a[w]] = 1'b0;
      end
    end
    if (rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0)))
      busy_d[rsv_addr] = 1'b1;
  end

  // storage and scoreboard, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // read ports look up the post-update state, giving write-first behaviour
  for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_rd
    logic zero_sel;
    assign zero_sel = (ZERO_REG != 0) && (raddr_a[r] == '0);

    regfile_mp_rdport #(.DATA_BITS(DATA_BITS)) u_rd (
      .clk      (clk),
      .reset_n  (reset_n),
      .ren      (ren[r]),
      .zero_sel (zero_sel),
      .data_in  (regs_d[raddr_a[r]]),
      .busy_in  (busy_d[raddr_a[r]]),
      .rdata    (rdata_a[r]),
      .rbusy    (rbusy[r])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench driving two configurations of regfile_mp
// (32b/32 regs/2R/2W and 64b/64 regs/4R/3W) from one directed stimulus stream.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [3:0]       wen_t;
  logic [3:0][5:0]  waddr_t;
  logic [3:0][63:0] wdata_t;
  logic             rsv_en;
  logic [5:0]       rsv_addr;
  logic [3:0]       ren_t;
  logic [3:0][5:0]  raddr_t;

  logic [1:0][31:0] rdata_a;
  logic [1:0]       rbusy_a;
  logic [31:0]      bv_a;
  logic [3:0][63:0] rdata_b;
  logic [3:0]       rbusy_b;
  logic [63:0]      bv_b;

  regfile_mp #(.DATA_BITS(32), .LOG2_NUM_REGISTERS(5), .NUM_READ_PORTS(2),
               .NUM_WRITE_PORTS(2), .ZERO_REG(1)) u_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .wen      (wen_t[1:0]),
    .waddr    ({waddr_t[1][4:0], waddr_t[0][4:0]}),
    .wdata    ({wdata_t[1][31:0], wdata_t[0][31:0]}),
    .rsv_en   (rsv_en & ~rsv_addr[5]),
    .rsv_addr (rsv_addr[4:0]),
    .ren      (ren_t[1:0]),
    .raddr    ({raddr_t[1][4:0], raddr_t[0][4:0]}),
    .rdata    (rdata_a),
    .rbusy    (rbusy_a),
    .busy_vec (bv_a)
  );

  regfile_mp #(.DATA_BITS(64), .LOG2_NUM_REGISTERS(6), .NUM_READ_PORTS(4),
               .NUM_WRITE_PORTS(3), .ZERO_REG(1)) u_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .wen      (wen_t[2:0]),
    .waddr    (waddr_t[2:0]),
    .wdata    (wdata_t[2:0]),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ren      (ren_t),
    .raddr    (raddr_t),
    .rdata    (rdata_b),
    .rbusy    (rbusy_b),
    .busy_vec (bv_b)
  );

  typedef struct { int p; logic [63:0] d; logic b; } rd_exp_t;
  typedef struct { int kind; int dut; int idx; logic [63:0] d; } chk_t;

  rd_exp_t qa[$];
  rd_exp_t qb[$];
  chk_t    chk_q[$];

  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  // read-valid: a port presents new data the edge after ren
  logic [1:0] vld_a;
  logic [3:0] vld_b;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_a <= '0;
      vld_b <= '0;
    end else begin
      vld_a <= ren_t[1:0];
      vld_b <= ren_t;
    end
  end

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // monitor: pops expectations when the DUT presents read data or a check is due
  always @(negedge clk) begin
    rd_exp_t e;
    chk_t    c;
    for (int p = 0; p < 2; p++) begin
      if (vld_a[p]) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_rd_unexpected: port %0d presented data with no expectation", p);
        end else begin
          e = qa.pop_front();
          cmp($sformatf("a_rdata%0d", p), {32'h0, rdata_a[p]}, e.d);
          cmp($sformatf("a_rbusy%0d", p), {63'h0, rbusy_a[p]}, {63'h0, e.b});
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (vld_b[p]) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_rd_unexpected: port %0d presented data with no expectation", p);
        end else begin
          e = qb.pop_front();
          cmp($sformatf("b_rdata%0d", p), rdata_b[p], e.d);
          cmp($sformatf("b_rbusy%0d", p), {63'h0, rbusy_b[p]}, {63'h0, e.b});
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        0: if (c.dut == 0) cmp($sformatf("a_busy_vec[%0d]", c.idx), {63'h0, bv_a[c.idx]}, c.d);
           else            cmp($sformatf("b_busy_vec[%0d]", c.idx), {63'h0, bv_b[c.idx]}, c.d);
        1: if (c.dut == 0) cmp($sformatf("a_hold%0d", c.idx), {32'h0, rdata_a[c.idx]}, c.d);
           else            cmp($sformatf("b_hold%0d", c.idx), rdata_b[c.idx], c.d);
        default: begin
          cmp("a_rdata_zero", rdata_a, 64'h0);
          cmp("a_rbusy_zero", {62'h0, rbusy_a}, 64'h0);
          cmp("a_busy_vec_zero", {32'h0, bv_a}, 64'h0);
          cmp("b_rdata_zero", {63'h0, |rdata_b}, 64'h0);
          cmp("b_rbusy_zero", {60'h0, rbusy_b}, 64'h0);
          cmp("b_busy_vec_zero", bv_b, 64'h0);
        end
      endcase
    end
    if (done) begin
      cmp("pending_expectations", 64'(qa.size() + qb.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic clr();
    wen_t = '0; waddr_t = '0; wdata_t = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    ren_t = '0; raddr_t = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input int p, input logic [5:0] a, input logic [63:0] d);
    wen_t[p] = 1'b1; waddr_t[p] = a; wdata_t[p] = d;
  endtask

  task automatic rsv(input logic [5:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  // call in ascending port order within a cycle
  task automatic rd(input int p, input logic [5:0] a, input logic [63:0] da, input logic ba,
                    input logic [63:0] db, input logic bb);
    ren_t[p] = 1'b1; raddr_t[p] = a;
    if (p < 2) qa.push_back('{p, da & 64'hFFFF_FFFF, ba});
    qb.push_back('{p, db, bb});
  endtask

  task automatic rd2(input int p, input logic [5:0] a, input logic [63:0] d, input logic b);
    rd(p, a, d, b, d, b);
  endtask

  task automatic bv(input int dut, input int idx, input logic e);
    chk_q.push_back('{0, dut, idx, {63'h0, e}});
  endtask

  task automatic bv2(input int idx, input logic e);
    bv(0, idx, e); bv(1, idx, e);
  endtask

  task automatic hold2(input int p, input logic [63:0] d);
    chk_q.push_back('{1, 0, p, d}); chk_q.push_back('{1, 1, p, d});
  endtask

  task automatic zero_chk();
    chk_q.push_back('{2, 0, 0, 64'h0});
  endtask

  initial begin
    reset_n = 1'b0;
    clr();
    // reset state
    repeat (2) @(posedge clk);
    #1;
    zero_chk();
    step();
    reset_n = 1'b1;

    // mid-cycle asynchronous reset
    wr(0, 5, 64'hDEAD_BEEF); step();
    rd2(0, 5, 64'hDEAD_BEEF, 1'b0); rsv(12); step(); bv2(12, 1'b1);
    step();
    #1 reset_n = 1'b0;
    zero_chk();
    step();
    reset_n = 1'b1;
    step(); zero_chk();
    rd2(0, 5, 64'h0, 1'b0); rd2(1, 12, 64'h0, 1'b0); step();

    // write-first bypass
    wr(0, 7, 64'h1111_1111); step();
    rd2(1, 7, 64'h1111_1111, 1'b0); step();
    wr(0, 7, 64'h1234_5678); rd2(1, 7, 64'h1234_5678, 1'b0); step();

    // write conflict: highest port wins (port 2 exists only on the wide DUT)
    wr(0, 3, 64'hAAAA_0000); wr(1, 3, 64'h0000_BBBB); wr(2, 3, 64'hCAFE_0000_0000_CCCC); step();
    rd(0, 3, 64'h0000_BBBB, 1'b0, 64'hCAFE_0000_0000_CCCC, 1'b0); step();

    // scoreboard
    rsv(9); rd2(0, 9, 64'h0, 1'b1); step(); bv2(9, 1'b1);
    wr(0, 9, 64'h55); step(); bv2(9, 1'b0);
    rd2(0, 9, 64'h55, 1'b0); step();
    rsv(9); wr(1, 9, 64'h55); rd2(0, 9, 64'h55, 1'b1); step(); bv2(9, 1'b1);

    // zero register
    wr(0, 0, 64'hFFFF_FFFF); rsv(0); rd2(1, 0, 64'h0, 1'b0); step(); bv2(0, 1'b0);
    rd2(0, 0, 64'h0, 1'b0); step();

    // hold while ren low
    wr(0, 4, 64'h44); step();
    rd2(0, 4, 64'h44, 1'b0); step();
    wr(0, 4, 64'h99); step(); hold2(0, 64'h44);
    step(); hold2(0, 64'h44);
    step(); hold2(0, 64'h44);
    rd2(0, 4, 64'h99, 1'b0); step();

    // wide-config only: upper registers, port 2 write, ports 2/3 read
    wr(2, 40, 64'h0123_4567_89AB_CDEF); rsv(41); step(); bv(1, 41, 1'b1);
    rd(2, 41, 64'h0, 1'b0, 64'h0, 1'b1); rd(3, 40, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0); step();

    step();
    done = 1'b1;
  end

endmodule
